// File: rtl/load_store_unit_if.sv
// load_store_unit_if: groups the pipeline request/response handshake and the
// data-memory beat bus of the load/store unit. The slave modport is the LSU
// view. The master modport is the view of the environment that issues
// requests and answers memory beats.
interface load_store_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   // Pipeline request side
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;

   // Data-memory beat side
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   // Completion and stall
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_fault;
   logic                  busy;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output rsp_valid, rsp_rdata, rsp_fault, busy
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  rsp_valid, rsp_rdata, rsp_fault, busy
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between the CPU datapath and
// data memory. It lane-shifts store data and drives byte enables, waits on
// the memory ack handshake, and returns sign- or zero-extended load data.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned
// accesses are legal. An access that crosses a lane boundary is split into
// two beats. When the macro is undefined, a misaligned access faults.
module load_store_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t              state_q;
   logic                ready_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [BYTES-1:0]    mem_be_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [BYTES-1:0]    be_hi_q;
   logic [DATA_W-1:0]   wdata_hi_q;
   logic                split_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic [OFF_W-1:0]    off_q;
   logic [DATA_W-1:0]   beat0_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_fault_q;

   // Request decode: lane offset, two-lane-wide enables and data, legality
   logic [OFF_W-1:0]    off_d;
   logic [BYTES-1:0]    len_mask_d;
   logic [2*BYTES-1:0]  be_d;
   logic [2*DATA_W-1:0] wdata_d;
   logic                fault_d;
   logic                split_d;

   // Load return path
   logic [2*DATA_W-1:0] cat_d;
   logic [DATA_W-1:0]   aligned_d;
   logic [DATA_W-1:0]   load_d;
   logic                sign_d;

   // Decode the incoming request into beat enables, shifted data and legality.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      off_d      = bus.req_addr[OFF_W-1:0];
      len_mask_d = '0;
      for (int i = 0; i < BYTES; i++) begin
         len_mask_d[i] = (i < (1 << bus.req_size));
      end
      be_d    = {{BYTES{1'b0}}, len_mask_d} << off_d;
      wdata_d = {{DATA_W{1'b0}}, bus.req_wdata} << {off_d, 3'b000};
      for (int b = 0; b < 2 * BYTES; b++) begin
         if (!be_d[b]) wdata_d[8*b +: 8] = 8'h00;
      end
      if (!bus.req_we) wdata_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      fault_d = (bus.req_size > 2'(OFF_W));
      split_d = (int'(off_d) + (1 << bus.req_size)) > BYTES;
`else
      fault_d = (bus.req_size > 2'(OFF_W)) ||
                ((off_d & OFF_W'((1 << bus.req_size) - 1)) != '0);
      split_d = 1'b0;
`endif
   end

   // Right-align the accessed bytes (BEAT0 bytes are low-order) and extend.
   always_comb begin
      cat_d     = (state_q == BEAT1) ? {bus.mem_rdata, beat0_q}
                                     : {{DATA_W{1'b0}}, bus.mem_rdata};
      aligned_d = DATA_W'(cat_d >> {off_q, 3'b000});
      sign_d    = 1'b0;
      for (int i = 0; i < BYTES; i++) begin
         if (i == (1 << size_q) - 1) sign_d = signed_q & aligned_d[8*i+7];
      end
      load_d = aligned_d;
      for (int i = 0; i < BYTES; i++) begin
         if (i >= (1 << size_q)) load_d[8*i +: 8] = {8{sign_d}};
      end
   end

   // Sequence accept, memory beats and the one-cycle response; outputs are flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         be_hi_q     <= '0;
         wdata_hi_q  <= '0;
         split_q     <= 1'b0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         off_q       <= '0;
         beat0_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every flop sees pre-edge values.
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  ready_q  <= 1'b0;
                  size_q   <= bus.req_size;
                  signed_q <= bus.req_signed;
                  off_q    <= off_d;
                  split_q  <= split_d;
                  mem_we_q <= bus.req_we;
                  if (fault_d) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_fault_q <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q     <= BEAT0;
                     mem_req_q   <= 1'b1;
                     mem_addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_be_q    <= be_d[BYTES-1:0];
                     be_hi_q     <= be_d[2*BYTES-1:BYTES];
                     mem_wdata_q <= wdata_d[DATA_W-1:0];
                     wdata_hi_q  <= wdata_d[2*DATA_W-1:DATA_W];
                  end
               end
            end
            BEAT0: begin
               if (bus.mem_ack) begin
                  if (split_q) begin
                     state_q     <= BEAT1;
                     beat0_q     <= bus.mem_rdata;
                     mem_addr_q  <= mem_addr_q + ADDR_W'(BYTES);
                     mem_be_q    <= be_hi_q;
                     mem_wdata_q <= wdata_hi_q;
                  end else begin
                     state_q     <= RESP;
                     mem_req_q   <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     rsp_fault_q <= 1'b0;
                     rsp_rdata_q <= mem_we_q ? '0 : load_d;
                  end
               end
            end
            BEAT1: begin
               if (bus.mem_ack) begin
                  state_q     <= RESP;
                  mem_req_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_fault_q <= 1'b0;
                  rsp_rdata_q <= mem_we_q ? '0 : load_d;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               ready_q     <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = ~ready_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. It uses a 32-bit
// instance for the main scenarios and a 64-bit instance for dword accesses.
// Expected responses are queued when a request is issued and popped when
// rsp_valid appears. Misaligned-access expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) bif ();
   load_store_unit_if #(.DATA_W(64), .ADDR_W(32)) bif64 ();

   load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bif));
   load_store_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bif64));

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } rsp32_t;

   rsp32_t      exp_q[$];
   logic [63:0] exp64_q[$];
   int          checks   = 0;
   int          failures = 0;

   // Place a request on the 32-bit port; returns just after the accepting edge.
   task automatic issue32(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      @(posedge clk); #1;
      checks++;
      if (bif.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready: got %b want 1", tag, bif.req_ready);
      end
      bif.req_we     = we;
      bif.req_size   = size;
      bif.req_signed = sgn;
      bif.req_addr   = addr;
      bif.req_wdata  = wdata;
      bif.req_valid  = 1'b1;
      @(posedge clk); #1;
      bif.req_valid  = 1'b0;
   endtask

   // Check one memory beat held for waits+1 cycles, then ack it with rdata.
   task automatic beat32(input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                         input logic [31:0] e_wd, input logic [31:0] rdata, input int waits,
                         input bit pulse, input string tag);
      for (int w = 0; w <= waits; w++) begin
         @(negedge clk);
         checks++;
         if (bif.mem_req !== 1'b1 || bif.mem_addr !== e_addr || bif.mem_be !== e_be ||
             bif.mem_we !== e_we || bif.mem_wdata !== e_wd || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s beat w%0d: got req=%b addr=%h be=%b we=%b wdata=%h busy=%b want req=1 addr=%h be=%b we=%b wdata=%h busy=1",
                     tag, w, bif.mem_req, bif.mem_addr, bif.mem_be, bif.mem_we, bif.mem_wdata,
                     bif.busy, e_addr, e_be, e_we, e_wd);
         end
         if (pulse && w == 1) begin
            bif.req_valid = 1'b1;
            bif.req_addr  = 32'h0000_7770;
         end
         if (pulse && w == 2) bif.req_valid = 1'b0;
      end
      bif.mem_ack   = 1'b1;
      bif.mem_rdata = rdata;
      @(posedge clk); #1;
      bif.mem_ack   = 1'b0;
      bif.mem_rdata = '0;
   endtask

   // Expect the response in the next cycle, compare it with the scoreboard, then expect a return to idle.
   task automatic resp32(input string tag);
      rsp32_t e;
      e = '0;
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s rsp: got rsp_valid=%b with empty scoreboard want queued entry", tag, bif.rsp_valid);
      end else begin
         e = exp_q.pop_front();
         if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== e.rdata || bif.rsp_fault !== e.fault ||
             bif.mem_req !== 1'b0 || bif.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s rsp: got valid=%b rdata=%h fault=%b mem_req=%b ready=%b want valid=1 rdata=%h fault=%b mem_req=0 ready=0",
                     tag, bif.rsp_valid, bif.rsp_rdata, bif.rsp_fault, bif.mem_req, bif.req_ready,
                     e.rdata, e.fault);
         end
      end
      @(negedge clk);
      checks++;
      if (bif.rsp_valid !== 1'b0 || bif.req_ready !== 1'b1 || bif.busy !== 1'b0 ||
          bif.mem_req !== 1'b0 || bif.rsp_rdata !== e.rdata || bif.rsp_fault !== e.fault) begin
         failures++;
         $display("FAIL %s idle: got valid=%b ready=%b busy=%b mem_req=%b rdata=%h fault=%b want 0 1 0 0 %h %b",
                  tag, bif.rsp_valid, bif.req_ready, bif.busy, bif.mem_req, bif.rsp_rdata,
                  bif.rsp_fault, e.rdata, e.fault);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bif.req_ready !== 1'b1 || bif.busy !== 1'b0 || bif.mem_req !== 1'b0 || bif.mem_we !== 1'b0 ||
          bif.mem_addr !== 32'h0 || bif.mem_be !== 4'h0 || bif.mem_wdata !== 32'h0 ||
          bif.rsp_valid !== 1'b0 || bif.rsp_rdata !== 32'h0 || bif.rsp_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset: got ready=%b busy=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b rd=%h rf=%b want ready=1 and all else 0",
                  bif.req_ready, bif.busy, bif.mem_req, bif.mem_we, bif.mem_addr, bif.mem_be,
                  bif.mem_wdata, bif.rsp_valid, bif.rsp_rdata, bif.rsp_fault);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.req_ready !== 1'b1 || bif.mem_req !== 1'b0 || bif.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got ready=%b req=%b rv=%b want 1 0 0", bif.req_ready, bif.mem_req, bif.rsp_valid);
      end
   endtask

   task automatic test_load_byte();
      exp_q.push_back('{rdata: 32'hFFFF_FF80, fault: 1'b0});
      issue32(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, "lb");
      beat32(32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_1234, 0, 1'b0, "lb");
      resp32("lb");
      exp_q.push_back('{rdata: 32'h0000_0080, fault: 1'b0});
      issue32(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, "lbu");
      beat32(32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_1234, 0, 1'b0, "lbu");
      resp32("lbu");
   endtask

   task automatic test_store();
      exp_q.push_back('{rdata: 32'h0, fault: 1'b0});
      issue32(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, "sh");
      beat32(32'h0000_2000, 4'b1100, 1'b1, 32'hBEEF_0000, 32'hDEAD_BEEF, 0, 1'b0, "sh");
      resp32("sh");
      exp_q.push_back('{rdata: 32'h0, fault: 1'b0});
      issue32(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'hFFFF_FF5A, "sb");
      beat32(32'h0000_2000, 4'b0010, 1'b1, 32'h0000_5A00, 32'h1111_1111, 0, 1'b0, "sb");
      resp32("sb");
      exp_q.push_back('{rdata: 32'h0, fault: 1'b0});
      issue32(1'b1, 2'd2, 1'b1, 32'h0000_2004, 32'h1234_5678, "sw");
      beat32(32'h0000_2004, 4'b1111, 1'b1, 32'h1234_5678, 32'h0, 0, 1'b0, "sw");
      resp32("sw");
   endtask

   task automatic test_half_sign();
      exp_q.push_back('{rdata: 32'hFFFF_9ABC, fault: 1'b0});
      issue32(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, "lh_neg");
      beat32(32'h0000_1000, 4'b1100, 1'b0, 32'h0, 32'h9ABC_0000, 0, 1'b0, "lh_neg");
      resp32("lh_neg");
      exp_q.push_back('{rdata: 32'h0000_8001, fault: 1'b0});
      issue32(1'b0, 2'd1, 1'b0, 32'h0000_1000, 32'h0, "lhu");
      beat32(32'h0000_1000, 4'b0011, 1'b0, 32'h0, 32'hFFFF_8001, 0, 1'b0, "lhu");
      resp32("lhu");
      exp_q.push_back('{rdata: 32'h0000_7FFF, fault: 1'b0});
      issue32(1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0, "lh_pos");
      beat32(32'h0000_1000, 4'b0011, 1'b0, 32'h0, 32'h8000_7FFF, 0, 1'b0, "lh_pos");
      resp32("lh_pos");
   endtask

   task automatic test_illegal_size();
      exp_q.push_back('{rdata: 32'h0, fault: 1'b1});
      issue32(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, "dword32");
      resp32("dword32");
   endtask

   task automatic test_misaligned();
`ifdef LSU_MISALIGN_SPLIT_EN
      exp_q.push_back('{rdata: 32'h11DD_CCBB, fault: 1'b0});
      issue32(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, "lw_split");
      beat32(32'h0000_3000, 4'b1110, 1'b0, 32'h0, 32'hDDCC_BBAA, 0, 1'b0, "lw_split0");
      beat32(32'h0000_3004, 4'b0001, 1'b0, 32'h0, 32'h4433_2211, 0, 1'b0, "lw_split1");
      resp32("lw_split");
      exp_q.push_back('{rdata: 32'hFFFF_ABCD, fault: 1'b0});
      issue32(1'b0, 2'd1, 1'b1, 32'h0000_1001, 32'h0, "lh_mis");
      beat32(32'h0000_1000, 4'b0110, 1'b0, 32'h0, 32'h00AB_CD00, 0, 1'b0, "lh_mis");
      resp32("lh_mis");
      exp_q.push_back('{rdata: 32'h0, fault: 1'b0});
      issue32(1'b1, 2'd2, 1'b0, 32'h0000_6003, 32'h1122_3344, "sw_split");
      beat32(32'h0000_6000, 4'b1000, 1'b1, 32'h4400_0000, 32'h0, 0, 1'b0, "sw_split0");
      beat32(32'h0000_6004, 4'b0111, 1'b1, 32'h0011_2233, 32'h0, 0, 1'b0, "sw_split1");
      resp32("sw_split");
`else
      exp_q.push_back('{rdata: 32'h0, fault: 1'b1});
      issue32(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, "lw_mis");
      resp32("lw_mis");
      exp_q.push_back('{rdata: 32'h0, fault: 1'b1});
      issue32(1'b0, 2'd1, 1'b1, 32'h0000_1001, 32'h0, "lh_mis");
      resp32("lh_mis");
      exp_q.push_back('{rdata: 32'h0, fault: 1'b1});
      issue32(1'b1, 2'd2, 1'b0, 32'h0000_6003, 32'h1122_3344, "sw_mis");
      resp32("sw_mis");
`endif
   endtask

   task automatic test_wait_states();
      exp_q.push_back('{rdata: 32'hCAFE_F00D, fault: 1'b0});
      issue32(1'b0, 2'd2, 1'b1, 32'h0000_5000, 32'h0, "lw_wait");
      beat32(32'h0000_5000, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D, 5, 1'b1, "lw_wait");
      resp32("lw_wait");
   endtask

   task automatic test_back_to_back();
      rsp32_t e;
      exp_q.push_back('{rdata: 32'h0000_007F, fault: 1'b0});
      exp_q.push_back('{rdata: 32'h0000_ABCD, fault: 1'b0});
      issue32(1'b0, 2'd0, 1'b1, 32'h0000_1000, 32'h0, "b2b_a");
      beat32(32'h0000_1000, 4'b0001, 1'b0, 32'h0, 32'h0000_007F, 0, 1'b0, "b2b_a");
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== e.rdata || bif.rsp_fault !== e.fault) begin
         failures++;
         $display("FAIL b2b_a rsp: got valid=%b rdata=%h fault=%b want 1 %h %b",
                  bif.rsp_valid, bif.rsp_rdata, bif.rsp_fault, e.rdata, e.fault);
      end
      bif.req_we     = 1'b0;
      bif.req_size   = 2'd1;
      bif.req_signed = 1'b0;
      bif.req_addr   = 32'h0000_1002;
      bif.req_valid  = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.req_ready !== 1'b1 || bif.mem_req !== 1'b0 || bif.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b idle: got ready=%b mem_req=%b rv=%b want 1 0 0", bif.req_ready, bif.mem_req, bif.rsp_valid);
      end
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      beat32(32'h0000_1000, 4'b1100, 1'b0, 32'h0, 32'hABCD_0000, 0, 1'b0, "b2b_b");
      resp32("b2b_b");
   endtask

   task automatic test_random_loads();
      logic [1:0]  sz;
      int          n;
      logic [31:0] addr, rd, sh, e, m;
      logic [1:0]  off;
      logic        sg;
      for (int k = 0; k < 8; k++) begin
         sz   = 2'($urandom_range(0, 2));
         n    = 1 << sz;
         addr = $urandom() & ~(32'(n) - 32'd1);
         off  = addr[1:0];
         rd   = $urandom();
         sg   = 1'($urandom_range(0, 1));
         sh   = rd >> (8 * off);
         case (sz)
            2'd0:    e = sg ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
            2'd1:    e = sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: e = sh;
         endcase
         m = ((32'd1 << n) - 32'd1) << off;
         exp_q.push_back('{rdata: e, fault: 1'b0});
         issue32(1'b0, sz, sg, addr, $urandom(), "rand");
         beat32(addr & ~32'h3, m[3:0], 1'b0, 32'h0, rd, k % 3, 1'b0, "rand");
         resp32("rand");
      end
   endtask

   task automatic test_reset_mid();
      issue32(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, "rst_mid");
      @(negedge clk);
      checks++;
      if (bif.mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid beat0: got mem_req=%b want 1", bif.mem_req);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bif.mem_req !== 1'b0 || bif.req_ready !== 1'b1 || bif.busy !== 1'b0 ||
          bif.mem_be !== 4'h0 || bif.mem_addr !== 32'h0 || bif.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid async: got req=%b ready=%b busy=%b be=%b addr=%h rv=%b want 0 1 0 0000 0 0",
                  bif.mem_req, bif.req_ready, bif.busy, bif.mem_be, bif.mem_addr, bif.rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bif.rsp_valid !== 1'b0 || bif.mem_req !== 1'b0 || bif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid after c%0d: got rv=%b req=%b ready=%b want 0 0 1",
                     i, bif.rsp_valid, bif.mem_req, bif.req_ready);
         end
      end
   endtask

   task automatic test_dword();
      logic [1:0]  t_size[2];
      logic        t_sgn[2];
      logic [31:0] t_addr[2];
      logic [7:0]  t_be[2];
      logic [63:0] t_rd[2];
      logic [63:0] e;
      t_size[0] = 2'd3; t_sgn[0] = 1'b1; t_addr[0] = 32'h08; t_be[0] = 8'hFF; t_rd[0] = 64'h8000_0000_0000_0001;
      t_size[1] = 2'd2; t_sgn[1] = 1'b1; t_addr[1] = 32'h0C; t_be[1] = 8'hF0; t_rd[1] = 64'h8000_0000_1234_5678;
      exp64_q.push_back(64'h8000_0000_0000_0001);
      exp64_q.push_back(64'hFFFF_FFFF_8000_0000);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         bif64.req_we     = 1'b0;
         bif64.req_size   = t_size[k];
         bif64.req_signed = t_sgn[k];
         bif64.req_addr   = t_addr[k];
         bif64.req_valid  = 1'b1;
         @(posedge clk); #1;
         bif64.req_valid  = 1'b0;
         @(negedge clk);
         checks++;
         if (bif64.mem_req !== 1'b1 || bif64.mem_addr !== 32'h08 || bif64.mem_be !== t_be[k]) begin
            failures++;
            $display("FAIL dword%0d beat: got req=%b addr=%h be=%b want 1 00000008 %b",
                     k, bif64.mem_req, bif64.mem_addr, bif64.mem_be, t_be[k]);
         end
         bif64.mem_ack   = 1'b1;
         bif64.mem_rdata = t_rd[k];
         @(posedge clk); #1;
         bif64.mem_ack   = 1'b0;
         bif64.mem_rdata = '0;
         @(negedge clk);
         e = exp64_q.pop_front();
         checks++;
         if (bif64.rsp_valid !== 1'b1 || bif64.rsp_rdata !== e || bif64.rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL dword%0d rsp: got valid=%b rdata=%h fault=%b want 1 %h 0",
                     k, bif64.rsp_valid, bif64.rsp_rdata, bif64.rsp_fault, e);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time got %0t want finish before limit", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bif.req_valid    = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'd0; bif.req_signed = 1'b0;
      bif.req_addr     = '0;   bif.req_wdata = '0; bif.mem_ack = 1'b0; bif.mem_rdata = '0;
      bif64.req_valid  = 1'b0; bif64.req_we = 1'b0; bif64.req_size = 2'd0; bif64.req_signed = 1'b0;
      bif64.req_addr   = '0;   bif64.req_wdata = '0; bif64.mem_ack = 1'b0; bif64.mem_rdata = '0;
      test_reset();
      test_load_byte();
      test_store();
      test_half_sign();
      test_illegal_size();
      test_misaligned();
      test_wait_states();
      test_back_to_back();
      test_random_loads();
      test_reset_mid();
      test_dword();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
